// File: rtl/imm_pkg.sv
// imm_pkg -- shared types and default widths for the pipelined immediate
// extender (imm_extend_core, imm_extend_pipe).
//   imm_src_e   : 3-bit mode selector encoding
//   pfx_state_e : prefix tracker states (used only when IMM_PREFIX_EN is set)
package imm_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_IMM_W   = 18;
  localparam int DEF_SHORT_W = 13;
  localparam int DEF_SHIFT   = 2;

  typedef enum logic [2:0] {
    IMM_ZERO   = 3'b000,
    IMM_SIGN   = 3'b001,
    IMM_BRANCH = 3'b010,
    IMM_UPPER  = 3'b011,
    IMM_PREFIX = 3'b100
  } imm_src_e;

  typedef enum logic {
    PFX_IDLE     = 1'b0,
    PFX_PREFIXED = 1'b1
  } pfx_state_e;

endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core -- combinational mode -> extended immediate function.
// Ports:
//   imm_src_i : mode selector (imm_src_e encoding)
//   instr_i   : instruction immediate field
//   pfx_act_i : a prefix is pending; ZERO/SIGN take their high bits from pfx_i
//   pfx_i     : prefix high bits (DATA_W-SHORT_W wide)
//   ext_imm_o : extended immediate (0 for illegal modes)
//   err_o     : illegal mode
// PREFIX (100) is reported illegal here; the pipe never registers the core
// output for an accepted PREFIX when prefix support is built in.
// Requires DATA_W >= IMM_W + SHIFT.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IMM_W   = DEF_IMM_W,
  parameter int SHORT_W = DEF_SHORT_W,
  parameter int SHIFT   = DEF_SHIFT
) (
  input  logic [2:0]                imm_src_i,
  input  logic [IMM_W-1:0]          instr_i,
  input  logic                      pfx_act_i,
  input  logic [DATA_W-SHORT_W-1:0] pfx_i,
  output logic [DATA_W-1:0]         ext_imm_o,
  output logic                      err_o
);

  logic [SHORT_W-1:0] s;
  logic [DATA_W-1:0]  zext, sext, pcat, bext, uext;

  assign s    = instr_i[SHORT_W-1:0];
  assign zext = DATA_W'(s);
  assign sext = DATA_W'($signed(s));
  assign pcat = {pfx_i, s};
  // Sign-extend the whole field first, then shift: the bits pushed out are
  // copies of the sign bit as long as DATA_W >= IMM_W + SHIFT.
  assign bext = DATA_W'($signed(instr_i)) << SHIFT;
  assign uext = DATA_W'(instr_i) << (DATA_W - IMM_W);

  always_comb begin
    ext_imm_o = '0;
    err_o     = 1'b0;
    case (imm_src_i)
      IMM_ZERO:   ext_imm_o = pfx_act_i ? pcat : zext;
      IMM_SIGN:   ext_imm_o = pfx_act_i ? pcat : sext;
      IMM_BRANCH: ext_imm_o = bext;
      IMM_UPPER:  ext_imm_o = uext;
      default:    err_o     = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe -- one-stage valid/ready registered immediate extender.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready = !out_valid || out_ready)
//   imm_src, instr      : mode selector and immediate field
//   flush               : drop pending output, prefix and same-cycle input
//   out_valid/out_ready : output handshake
//   ext_imm, err        : registered result, held while stalled
// Build option: IMM_PREFIX_EN enables PREFIX mode (100), the prefix register
// and its IDLE/PREFIXED tracker. Without it, 100 is an illegal mode.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IMM_W   = DEF_IMM_W,
  parameter int SHORT_W = DEF_SHORT_W,
  parameter int SHIFT   = DEF_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        imm_src,
  input  logic [IMM_W-1:0]  instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_imm,
  output logic              err
);

  localparam int PW = DATA_W - SHORT_W;

  logic              accept;
  logic              is_pfx;
  logic              pfx_act;
  logic [PW-1:0]     pfx_val;
  logic [DATA_W-1:0] core_imm;
  logic              core_err;

  logic              vld_q;
  logic [DATA_W-1:0] imm_q;
  logic              err_q;

  assign in_ready = !rst && (!vld_q || out_ready);
  // flush wins over a same-cycle input
  assign accept   = in_valid && in_ready && !flush;

`ifdef IMM_PREFIX_EN
  pfx_state_e    state_q, state_d;
  logic [PW-1:0] pfx_q, pfx_d;

  assign is_pfx = (imm_src == IMM_PREFIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PFX_IDLE;
      pfx_q   <= '0;
    end else begin
      state_q <= state_d;
      pfx_q   <= pfx_d;
    end
  end

  // Any accepted non-PREFIX input consumes the prefix, even if its mode
  // ignores it or is illegal.
  always_comb begin
    state_d = state_q;
    pfx_d   = pfx_q;
    if (flush) begin
      state_d = PFX_IDLE;
      pfx_d   = '0;
    end else if (accept) begin
      if (is_pfx) begin
        state_d = PFX_PREFIXED;
        pfx_d   = PW'($signed(instr));
      end else begin
        state_d = PFX_IDLE;
      end
    end
  end

  always_comb begin
    pfx_act = (state_q == PFX_PREFIXED);
    pfx_val = pfx_q;
  end
`else
  assign is_pfx  = 1'b0;
  assign pfx_act = 1'b0;
  assign pfx_val = '0;
`endif

  imm_extend_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .SHORT_W(SHORT_W),
    .SHIFT  (SHIFT)
  ) u_core (
    .imm_src_i(imm_src),
    .instr_i  (instr),
    .pfx_act_i(pfx_act),
    .pfx_i    (pfx_val),
    .ext_imm_o(core_imm),
    .err_o    (core_err)
  );

  // Data only loads on an accepted non-PREFIX input, so it stays stable
  // while stalled and after the consumer drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      imm_q <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept && !is_pfx) begin
      vld_q <= 1'b1;
      imm_q <= core_imm;
      err_q <= core_err;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign ext_imm   = imm_q;
  assign err       = err_q;

endmodule
